// File: rtl/io_port_bank.sv
// io_port_bank
//   Memory-mapped I/O peripheral beside the data RAM: CHANNELS read-only input
//   ports, a read/write output register, a status register with sticky error
//   bits, and a sequential double-dabble converter driving sign-magnitude
//   seven-segment BCD digits.
//   Optional feature: define IO_PORT_SYNC_EN to put a 2-flop synchroniser on
//   every input channel (pin-to-read latency becomes 3 cycles instead of 1).
//   Sizing: 10**DIGITS must exceed 2**(WIDTH-1) so the largest magnitude fits.

`ifdef IO_PORT_SYNC_EN
// Per-channel 2-flop synchroniser
module io_port_sync_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] val
);
  logic [WIDTH-1:0] meta;

  // two-stage capture of the asynchronous pins
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      meta <= '0;
      val  <= '0;
    end else begin
      meta <= pin;
      val  <= meta;
    end
endmodule
`endif

module io_port_bank #(
  parameter int                WIDTH     = 8,
  parameter int                CHANNELS  = 7,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] IN_BASE   = 8'hF0,
  parameter logic [ADDR_W-1:0] OUT_ADDR  = 8'hFE,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 8'hFF,
  parameter int                DIGITS    = 3
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      bus_readWriteN,
  input  logic [ADDR_W-1:0]         bus_address,
  input  logic [WIDTH-1:0]          bus_wdata,
  output logic [WIDTH-1:0]          bus_rdata,
  output logic                      bus_hit,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [3:0]                seven_seg_sign,
  output logic [4*DIGITS-1:0]       seven_seg_digits,
  output logic                      conv_busy,
  output logic                      error
);

  localparam int BCD_W = 4*DIGITS;
  localparam int CNT_W = $clog2(WIDTH+1);

  localparam logic [3:0] SIGN_MINUS = 4'hF;
  localparam logic [3:0] SIGN_BLANK = 4'hE;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} conv_state_t;

  // ---------------------------------------------------------------------------
  // Input channels
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0][WIDTH-1:0] ch;

`ifdef IO_PORT_SYNC_EN
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    io_port_sync_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .resetN (resetN),
      .pin    (in_data[k*WIDTH +: WIDTH]),
      .val    (ch[k])
    );
  end
`else
  assign ch = in_data;
`endif

  logic in_sign_err;

  // any negative-looking input channel flags a sign error
  always_comb begin
    in_sign_err = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      in_sign_err = in_sign_err | ch[k][WIDTH-1];
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // Offset computed one bit wider so addresses below IN_BASE wrap to a large
  // value and fall outside the channel window.
  logic [ADDR_W:0]  ch_off;
  logic             ch_hit, out_hit, stat_hit, any_hit;
  logic [WIDTH-1:0] ch_rd;

  assign ch_off   = {1'b0, bus_address} - {1'b0, IN_BASE};
  assign ch_hit   = ch_off < (ADDR_W+1)'(CHANNELS);
  assign out_hit  = bus_address == OUT_ADDR;
  assign stat_hit = bus_address == STAT_ADDR;
  assign any_hit  = ch_hit | out_hit | stat_hit;

  // select the addressed channel
  always_comb begin
    ch_rd = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (ch_off == (ADDR_W+1)'(k)) ch_rd = ch[k];
  end

  logic wr_out, wr_stat_clr;
  assign wr_out      = !bus_readWriteN && out_hit;
  assign wr_stat_clr = !bus_readWriteN && stat_hit && bus_wdata[0];

  // ---------------------------------------------------------------------------
  // Output register and sticky status
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_reg;
  logic             neg_sticky, ovf_sticky;

  // output register loads on every OUT_ADDR write
  always_ff @(posedge clk or negedge resetN)
    if (!resetN)     out_reg <= '0;
    else if (wr_out) out_reg <= bus_wdata;

  // sticky flags: a set in the same edge as a clear wins
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      neg_sticky <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (wr_out && bus_wdata[WIDTH-1])
        neg_sticky <= 1'b1;
      else if (wr_stat_clr)
        neg_sticky <= 1'b0;
      // nonzero store over a negative value that differs from it: a wrapped result
      if (wr_out && (|bus_wdata) && out_reg[WIDTH-1] && (bus_wdata != out_reg))
        ovf_sticky <= 1'b1;
      else if (wr_stat_clr)
        ovf_sticky <= 1'b0;
    end

  assign error = in_sign_err | neg_sticky | ovf_sticky | out_reg[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Bus read path
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stat_val, rd_mux;

  // status word layout and read-data mux
  always_comb begin
    stat_val      = '0;
    stat_val[3:0] = {conv_busy, in_sign_err, ovf_sticky, neg_sticky};
    rd_mux        = '0;
    if (ch_hit)        rd_mux = ch_rd;
    else if (out_hit)  rd_mux = out_reg;
    else if (stat_hit) rd_mux = stat_val;
  end

  // registered read data and hit; writes leave rdata untouched
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      bus_rdata <= '0;
      bus_hit   <= 1'b0;
    end else begin
      bus_hit <= any_hit;
      if (bus_readWriteN) bus_rdata <= rd_mux;
    end

  // ---------------------------------------------------------------------------
  // Binary-to-BCD converter FSM
  // ---------------------------------------------------------------------------
  conv_state_t      state, state_nxt;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] mag;
  logic [BCD_W-1:0] bcd, bcd_adj;
  logic             conv_sign;

  // state register
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;

  // next state: an output write always (re)starts at LOAD
  always_comb begin
    state_nxt = state;
    if (wr_out) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_LOAD:  state_nxt = S_SHIFT;
        S_SHIFT: if (shift_cnt == CNT_W'(WIDTH-1)) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    conv_busy = (state != S_IDLE);
  end

  // double-dabble correction: nibbles of 5 or more get +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
  end

  // conversion datapath; an aborting write suppresses the current step
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      shift_cnt        <= '0;
      mag              <= '0;
      bcd              <= '0;
      conv_sign        <= 1'b0;
      seven_seg_digits <= '0;
      seven_seg_sign   <= SIGN_BLANK;
    end else if (!wr_out) begin
      case (state)
        S_LOAD: begin
          // WIDTH-bit magnitude holds -2**(WIDTH-1) exactly as an unsigned value
          conv_sign <= out_reg[WIDTH-1];
          mag       <= out_reg[WIDTH-1] ? -out_reg : out_reg;
          bcd       <= '0;
          shift_cnt <= '0;
        end
        S_SHIFT: begin
          bcd       <= {bcd_adj[BCD_W-2:0], mag[WIDTH-1]};
          mag       <= {mag[WIDTH-2:0], 1'b0};
          shift_cnt <= shift_cnt + 1'b1;
        end
        S_DONE: begin
          // digits and sign change together so the display never tears
          seven_seg_digits <= bcd;
          seven_seg_sign   <= conv_sign ? SIGN_MINUS : SIGN_BLANK;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: randomized and directed checks of io_port_bank against a
// cycle-level behavioural model (decimal arithmetic, countdown timing).
module tb_io_port_bank;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 7;
  localparam int DIGITS   = 3;
  localparam int CONV_LAT = WIDTH + 2;
`ifdef IO_PORT_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int RD_LAT = SYNC ? 3 : 1;

  logic                      clk = 1'b0;
  logic                      resetN;
  logic                      rw;
  logic [7:0]                addr;
  logic [7:0]                wdata;
  logic [7:0]                bus_rdata;
  logic                      bus_hit;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [3:0]                seven_seg_sign;
  logic [4*DIGITS-1:0]       seven_seg_digits;
  logic                      conv_busy;
  logic                      error;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(8),
    .IN_BASE(8'hF0), .OUT_ADDR(8'hFE), .STAT_ADDR(8'hFF), .DIGITS(DIGITS)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .bus_readWriteN   (rw),
    .bus_address      (addr),
    .bus_wdata        (wdata),
    .bus_rdata        (bus_rdata),
    .bus_hit          (bus_hit),
    .in_data          (in_data),
    .seven_seg_sign   (seven_seg_sign),
    .seven_seg_digits (seven_seg_digits),
    .conv_busy        (conv_busy),
    .error            (error)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]                m_out, m_rdata, m_val;
  bit                        m_hit, m_neg, m_ovf;
  int                        m_left;
  logic [11:0]               m_dig;
  logic [3:0]                m_sign;
  logic [CHANNELS*WIDTH-1:0] m_s1, m_s2;

  function automatic logic [11:0] bcd_of(logic [7:0] v);
    int m;
    m = v[7] ? 256 - int'(v) : int'(v);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic bit sign_err(logic [CHANNELS*WIDTH-1:0] c);
    for (int k = 0; k < CHANNELS; k++) if (c[k*8+7]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_error();
    return sign_err(SYNC ? m_s2 : in_data) | m_neg | m_ovf | m_out[7];
  endfunction

  task automatic model_reset();
    m_out = 0; m_rdata = 0; m_val = 0; m_hit = 0; m_neg = 0; m_ovf = 0;
    m_left = 0; m_dig = 0; m_sign = 4'hE; m_s1 = 0; m_s2 = 0;
  endtask

  // one clock edge: DUT and model both advance with the inputs held now
  task automatic step();
    bit r; logic [7:0] a, d; logic [CHANNELS*WIDTH-1:0] cv, pin;
    r = rw; a = addr; d = wdata; pin = in_data;
    cv = SYNC ? m_s2 : in_data;
    @(posedge clk);
    if (r) begin
      m_rdata = 8'h00;
      if (a >= 8'hF0 && a <= 8'hF6) m_rdata = cv[(int'(a) - 'hF0)*8 +: 8];
      else if (a == 8'hFE)          m_rdata = m_out;
      else if (a == 8'hFF)          m_rdata = {4'b0, m_left > 0, sign_err(cv), m_ovf, m_neg};
    end
    m_hit = (a >= 8'hF0 && a <= 8'hF6) || a == 8'hFE || a == 8'hFF;
    if (!r && a == 8'hFF && d[0]) begin m_neg = 0; m_ovf = 0; end
    if (!r && a == 8'hFE) begin
      if (d != 0 && m_out[7] && d != m_out) m_ovf = 1;
      if (d[7]) m_neg = 1;
      m_out = d; m_val = d; m_left = CONV_LAT;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_dig = bcd_of(m_val); m_sign = m_val[7] ? 4'hF : 4'hE; end
    end
    m_s2 = m_s1; m_s1 = pin;
    #1;
  endtask

  task automatic bus_wr(logic [7:0] a, logic [7:0] d);
    rw = 1'b0; addr = a; wdata = d; step();
    rw = 1'b1; addr = 8'h00; wdata = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0; rw = 1'b1; addr = 8'h00; wdata = 8'h00; in_data = '0;
    #12; model_reset();
    n_checks += 5;
    if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", bus_rdata); end
    if (bus_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", bus_hit); end
    if (conv_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", conv_busy); end
    if (seven_seg_sign !== 4'hE) begin n_fail++; $display("FAIL reset_sign got %h want E", seven_seg_sign); end
    if (seven_seg_digits !== 12'h000) begin n_fail++; $display("FAIL reset_digits got %h want 000", seven_seg_digits); end
    @(negedge clk); resetN = 1'b1;
    addr = 8'hFF; step();
    n_checks += 3;
    if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_stat got %h want 00", bus_rdata); end
    if (bus_hit !== 1'b1) begin n_fail++; $display("FAIL reset_stat_hit got %b want 1", bus_hit); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    addr = 8'h00;
  endtask

  task automatic test_convert_pos();
    int busy_cnt = 0;
    bus_wr(8'hFE, 8'd127);
    repeat (CONV_LAT + 4) begin if (conv_busy === 1'b1) busy_cnt++; step(); end
    n_checks += 4;
    if (busy_cnt != CONV_LAT) begin n_fail++; $display("FAIL pos_busy_cycles got %0d want %0d", busy_cnt, CONV_LAT); end
    if (seven_seg_digits !== 12'h127) begin n_fail++; $display("FAIL pos_digits got %h want 127", seven_seg_digits); end
    if (seven_seg_sign !== 4'hE) begin n_fail++; $display("FAIL pos_sign got %h want E", seven_seg_sign); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL pos_error got %b want 0", error); end
  endtask

  task automatic test_convert_neg();
    bus_wr(8'hFE, 8'h80);
    repeat (CONV_LAT + 2) step();
    n_checks += 3;
    if (seven_seg_digits !== 12'h128) begin n_fail++; $display("FAIL neg_digits got %h want 128", seven_seg_digits); end
    if (seven_seg_sign !== 4'hF) begin n_fail++; $display("FAIL neg_sign got %h want F", seven_seg_sign); end
    if (error !== 1'b1) begin n_fail++; $display("FAIL neg_error got %b want 1", error); end
    addr = 8'hFF; step(); addr = 8'h00;
    n_checks++;
    if (bus_rdata !== 8'h01) begin n_fail++; $display("FAIL neg_stat got %h want 01", bus_rdata); end
    bus_wr(8'hFE, 8'd5);
    repeat (CONV_LAT + 2) step();
    addr = 8'hFF; step(); addr = 8'h00;
    n_checks++;
    if (bus_rdata !== 8'h03) begin n_fail++; $display("FAIL ovf_stat got %h want 03", bus_rdata); end
    bus_wr(8'hFF, 8'h01);
    n_checks += 3;
    if (error !== 1'b0) begin n_fail++; $display("FAIL clear_error got %b want 0", error); end
    if (seven_seg_digits !== 12'h005) begin n_fail++; $display("FAIL five_digits got %h want 005", seven_seg_digits); end
    if (seven_seg_sign !== 4'hE) begin n_fail++; $display("FAIL five_sign got %h want E", seven_seg_sign); end
  endtask

  task automatic test_input_channel();
    in_data = '0; in_data[3*8 +: 8] = 8'h9C;
    rw = 1'b1; addr = 8'hF3;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == RD_LAT - 1) begin
        n_checks++;
        if (bus_rdata === 8'h9C) begin n_fail++; $display("FAIL chan_early got %h want not 9C", bus_rdata); end
      end
      if (i == RD_LAT) begin
        n_checks++;
        if (bus_rdata !== 8'h9C) begin n_fail++; $display("FAIL chan_latency got %h want 9C", bus_rdata); end
      end
    end
    n_checks += 2;
    if (error !== 1'b1) begin n_fail++; $display("FAIL chan_error got %b want 1", error); end
    if (bus_hit !== 1'b1) begin n_fail++; $display("FAIL chan_hit got %b want 1", bus_hit); end
    addr = 8'hF7; step();
    n_checks += 2;
    if (bus_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit got %b want 0", bus_hit); end
    if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL miss_rdata got %h want 00", bus_rdata); end
    in_data = '0; addr = 8'h00;
    repeat (3) step();
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL chan_release_error got %b want 0", error); end
  endtask

  task automatic test_back_to_back();
    rw = 1'b0; addr = 8'hFE; wdata = 8'h90; step();
    wdata = 8'h91; step();
    rw = 1'b1; addr = 8'hFF; step();
    n_checks++;
    if (bus_rdata !== 8'h0B) begin n_fail++; $display("FAIL b2b_stat got %h want 0B", bus_rdata); end
    bus_wr(8'hFF, 8'h02);
    addr = 8'hFF; step();
    n_checks++;
    if (bus_rdata !== 8'h0B) begin n_fail++; $display("FAIL noclear_stat got %h want 0B", bus_rdata); end
    bus_wr(8'hFF, 8'h01);
    addr = 8'hFF; step();
    n_checks++;
    if (bus_rdata !== 8'h08) begin n_fail++; $display("FAIL clear_stat got %h want 08", bus_rdata); end
    addr = 8'hFE; step(); addr = 8'h00;
    n_checks++;
    if (bus_rdata !== 8'h91) begin n_fail++; $display("FAIL out_readback got %h want 91", bus_rdata); end
    repeat (CONV_LAT + 2) step();
    n_checks += 2;
    if (seven_seg_digits !== 12'h111) begin n_fail++; $display("FAIL b2b_digits got %h want 111", seven_seg_digits); end
    if (seven_seg_sign !== 4'hF) begin n_fail++; $display("FAIL b2b_sign got %h want F", seven_seg_sign); end
  endtask

  task automatic test_abort();
    bit seen42 = 1'b0;
    bus_wr(8'hFE, 8'd42);
    step(); step();
    bus_wr(8'hFE, 8'd99);
    repeat (CONV_LAT + 4) begin
      if (seven_seg_digits === 12'h042) seen42 = 1'b1;
      step();
    end
    n_checks += 3;
    if (seen42) begin n_fail++; $display("FAIL abort_shows_042 got 042 want never"); end
    if (seven_seg_digits !== 12'h099) begin n_fail++; $display("FAIL abort_digits got %h want 099", seven_seg_digits); end
    if (conv_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", conv_busy); end
  endtask

  task automatic test_reset_mid();
    bus_wr(8'hFE, 8'h85);
    repeat (4) step();
    #2 resetN = 1'b0;
    #1;
    model_reset();
    n_checks += 4;
    if (conv_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", conv_busy); end
    if (seven_seg_digits !== 12'h000) begin n_fail++; $display("FAIL midrst_digits got %h want 000", seven_seg_digits); end
    if (seven_seg_sign !== 4'hE) begin n_fail++; $display("FAIL midrst_sign got %h want E", seven_seg_sign); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL midrst_error got %b want 0", error); end
    @(negedge clk); resetN = 1'b1;
    repeat (CONV_LAT + 2) step();
    n_checks++;
    if (seven_seg_digits !== 12'h000) begin n_fail++; $display("FAIL postrst_digits got %h want 000", seven_seg_digits); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [10] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hFE, 8'hFF};
    for (int c = 0; c < 400; c++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) in_data = {$urandom, $urandom} & {CHANNELS{8'h7F | 8'($urandom_range(0, 7) == 0) << 7}};
      if (op < 12)      begin rw = 1'b0; addr = 8'hFE; wdata = 8'($urandom); end
      else if (op < 16) begin rw = 1'b0; addr = 8'hFF; wdata = 8'($urandom); end
      else if (op < 20) begin rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom); end
      else              begin rw = 1'b1; addr = addrs[$urandom_range(0, 9)]; wdata = 8'($urandom); end
      step();
      n_checks += 6;
      if (bus_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc %0d got %h want %h", c, bus_rdata, m_rdata); end
      if (bus_hit !== m_hit) begin n_fail++; $display("FAIL rnd_hit cyc %0d got %b want %b", c, bus_hit, m_hit); end
      if (conv_busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, conv_busy, m_left > 0); end
      if (seven_seg_digits !== m_dig) begin n_fail++; $display("FAIL rnd_digits cyc %0d got %h want %h", c, seven_seg_digits, m_dig); end
      if (seven_seg_sign !== m_sign) begin n_fail++; $display("FAIL rnd_sign cyc %0d got %h want %h", c, seven_seg_sign, m_sign); end
      if (error !== exp_error()) begin n_fail++; $display("FAIL rnd_error cyc %0d got %b want %b", c, error, exp_error()); end
    end
    rw = 1'b1; addr = 8'h00; in_data = '0;
  endtask

  initial begin
    test_reset();
    test_convert_pos();
    test_convert_neg();
    test_input_channel();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised memory-mapped I/O block that sits beside the data RAM on the processor bus. It provides CHANNELS read-only input ports with optional synchronisation, a read/write output register, and a status/error register with sticky error bits. A sequential binary-to-BCD converter drives sign-magnitude seven-segment digits. It replaces hard-wired input mapping and combinational display encoding with an addressable, width-generic peripheral.

## Interface
- WIDTH, 8: data width of every channel, the output register and the bus.
- CHANNELS, 7: number of input ports, 1..16.
- ADDR_W, 8: bus address width.
- IN_BASE, 8'hF0: address of channel 0; channel k is at IN_BASE+k.
- OUT_ADDR, 8'hFE: output register address.
- STAT_ADDR, 8'hFF: status register address.
- DIGITS, 3: BCD digits produced; must satisfy 10^DIGITS > 2^(WIDTH-1).
- clk  in  1  system clock; all state changes on the rising edge.
- resetN  in  1  asynchronous active-low reset.
- bus_readWriteN  in  1  1 = read, 0 = write.
- bus_address  in  ADDR_W  bus address.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  registered read data.
- bus_hit  out  1  registered; 1 when the previous cycle's address decoded to this block.
- in_data  in  CHANNELS*WIDTH  packed inputs; channel k is bits [k*WIDTH +: WIDTH].
- seven_seg_sign  out  4  4'hF = minus, 4'hE = blank.
- seven_seg_digits  out  4*DIGITS  BCD digits; digit 0 (units) is the LSBs.
- conv_busy  out  1  conversion in progress.
- error  out  1  aggregated error flag.

## Operation
- Address decode: hit when bus_address is in [IN_BASE, IN_BASE+CHANNELS-1], or equals OUT_ADDR or STAT_ADDR. Any other address gives no hit and no side effect.
- Reads are side-effect free:
  - Channel reads return the (synchronised) input.
  - OUT_ADDR returns the output register.
  - STAT_ADDR returns {zeros, conv_busy, in_sign_err, ovf_sticky, neg_sticky} in bits [3:0].
- Writes to input channels are ignored.
- Write to OUT_ADDR: load the output register and start a conversion.
- Write to STAT_ADDR with bit0 = 1: clear both sticky bits. Other bits are ignored.
- in_sign_err (combinational): OR of the MSB of every synchronised channel.
- neg_sticky: set when the output register is loaded with MSB = 1.
- ovf_sticky: set when an OUT_ADDR write carries a nonzero bus_wdata while the output register MSB = 1 and the value differs from the previous load. This marks a processor store of a wrapped result.
- error = in_sign_err | neg_sticky | ovf_sticky | output register MSB.
- Converter FSM, states IDLE -> LOAD -> SHIFT(WIDTH cycles) -> DONE -> IDLE:
  - LOAD: latch sign and magnitude (two's-complement negate when negative; magnitude is WIDTH bits, so -2^(WIDTH-1) is represented exactly).
  - SHIFT: double-dabble, add 3 to each BCD nibble >= 5, then shift left one bit.
  - DONE: copy BCD into seven_seg_digits and sign into seven_seg_sign atomically, then return to IDLE.
- A write to OUT_ADDR in any non-IDLE state aborts and restarts at LOAD with the new value. The displayed digits keep their old value until a DONE.

## Timing
- Reset values:
  - bus_rdata = 0, bus_hit = 0, output register = 0, sticky bits = 0.
  - FSM = IDLE, conv_busy = 0.
  - seven_seg_sign = 4'hE, seven_seg_digits = 0, synchroniser flops = 0.
- Read latency: 1 cycle. rdata/hit reflect the address sampled at the previous edge.
- Write takes effect at the sampling edge; a read of OUT_ADDR in the next cycle returns the new value.
- Conversion: write at edge N gives conv_busy = 1 from N+1. Display updates and conv_busy falls at edge N+WIDTH+2.
- Sticky clear and sticky set in the same edge: set wins.
- Reset asserted mid-conversion: immediate return to IDLE with reset values; no partial digits are shown.

## Configuration
- IO_PORT_SYNC_EN:
  - Defined: each channel passes through a 2-flop synchroniser, and channel reads observe in_data 2 edges later. Total read latency from a pin change is 3 cycles.
  - Undefined: channels are read directly, with read latency 1 cycle from a pin change.

## Test plan
- Reset, then read STAT_ADDR -> bus_rdata = 0, error = 0, seven_seg_sign = 4'hE, digits = 000.
- Write 8'd127 to OUT_ADDR -> conv_busy high for 10 cycles, then digits = 1,2,7, sign = 4'hE, error = 0.
- Write 8'h80 -> digits = 1,2,8, sign = 4'hF, neg_sticky = 1, error = 1. Then write 8'd5 and 1 to STAT_ADDR -> error = 0, digits = 005.
- Drive channel 3 = 8'h9C and read IN_BASE+3 -> 8'h9C after 1 cycle (3 cycles with IO_PORT_SYNC_EN), and error = 1 while the MSB is held.
- Write 8'd42, then write 8'd99 three cycles later -> digits never show 042 and end at 099. Reset pulse mid-conversion -> digits = 000, conv_busy = 0.
